// File: rtl/instruction_fetch_if.sv
// ============================================================================
// Module      : instruction_fetch_if
// Description : Memory, redirect/halt and decode-handshake bundle for the fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface instruction_fetch_if #(
  parameter int I_ADDR_W = 12,
  parameter int INST_W   = 16
) ();
  logic [I_ADDR_W-1:0] imem_addr;
  logic [INST_W-1:0]   imem_instruction;
  logic                redirect_valid;
  logic [I_ADDR_W-1:0] redirect_target;
  logic                halt_req;
  logic                out_valid;
  logic                out_ready;
  logic [INST_W-1:0]   out_instruction;
  logic [I_ADDR_W-1:0] out_pc;
  logic                halted;

  // master is the fetch stage; slave is memory + decode + control
  modport master (
    output imem_addr, out_valid, out_instruction, out_pc, halted,
    input  imem_instruction, redirect_valid, redirect_target, halt_req, out_ready
  );

  modport slave (
    input  imem_addr, out_valid, out_instruction, out_pc, halted,
    output imem_instruction, redirect_valid, redirect_target, halt_req, out_ready
  );
endinterface

`default_nettype wire

// File: rtl/instruction_fetch.sv
// ============================================================================
// Module      : instruction_fetch
// Description : PC + IF/ID register with valid/ready output, redirect and halt.
//               Optional perf counters under INSTRUCTION_FETCH_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetch #(
  parameter int                I_ADDR_W = 12,
  parameter int                INST_W   = 16,
  parameter logic [I_ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 2
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
`ifdef INSTRUCTION_FETCH_PERF_EN
  output      logic [15:0]        perf_fetch_count,
  output      logic [15:0]        perf_stall_count,
`endif
  instruction_fetch_if.master     bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [I_ADDR_W-1:0] ALIGN_MASK = ~{{(I_ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [I_ADDR_W-1:0] STEP       = I_ADDR_W'(PC_STEP);

  state_t              state_q, state_d;
  logic [I_ADDR_W-1:0] pc_q, pc_d;
  logic                out_valid_q, out_valid_d;
  logic [INST_W-1:0]   out_instr_q, out_instr_d;
  logic [I_ADDR_W-1:0] out_pc_q, out_pc_d;
  logic                load_en;
  logic                redirect_take;

  assign redirect_take = bus.redirect_valid && (state_q != IDLE);
  assign load_en = (state_q == FETCH) && (!out_valid_q || bus.out_ready)
                   && !bus.redirect_valid && !bus.halt_req;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;

    case (state_q)
      IDLE:    state_d = FETCH;
      FETCH:   if (bus.halt_req) state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = IDLE;
    endcase

    // Redirect flushes the IF/ID register and wins over both load and halt
    if (redirect_take) begin
      pc_d        = bus.redirect_target & ALIGN_MASK;
      out_valid_d = 1'b0;
      state_d     = bus.halt_req ? HALTED : FETCH;
    end else if (load_en) begin
      out_instr_d = bus.imem_instruction;
      out_pc_d    = pc_q;
      out_valid_d = 1'b1;
      pc_d        = pc_q + STEP;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_pc_q    <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
    end
  end

  assign bus.imem_addr       = pc_q;
  assign bus.out_valid       = out_valid_q;
  assign bus.out_instruction = out_instr_q;
  assign bus.out_pc          = out_pc_q;
  assign bus.halted          = (state_q == HALTED);

`ifdef INSTRUCTION_FETCH_PERF_EN
  logic [15:0] fetch_cnt_q, fetch_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (load_en && (fetch_cnt_q != 16'hFFFF))
      fetch_cnt_d = fetch_cnt_q + 16'd1;
    if (out_valid_q && !bus.out_ready && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_fetch_count = fetch_cnt_q;
  assign perf_stall_count = stall_cnt_q;
`endif

endmodule

`default_nettype wire

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage of the CPU; sits directly upstream of the instruction memory.
- Holds the program counter (PC) and drives the memory's byte address.
- Captures the combinationally-returned little-endian instruction into an IF/ID output register.
- Presents {instruction, pc} to decode over a valid/ready handshake; supports branch/jump redirect and halt.

Parameters:
- I_ADDR_W, 12, byte address width; PC width.
- INST_W, 16, instruction width in bits.
- RESET_PC, 0, PC value loaded on reset; bit 0 must be 0.
- PC_STEP, 2, bytes per instruction (INST_W/8).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- imem_addr  output  I_ADDR_W  byte address to instruction memory; equals PC register.
- imem_instruction  input  INST_W  instruction returned combinationally for imem_addr.
- redirect_valid  input  1  branch/jump taken this cycle.
- redirect_target  input  I_ADDR_W  new PC; bit 0 is ignored and forced to 0.
- halt_req  input  1  stop fetching after the current cycle.
- out_valid  output  1  IF/ID register holds a valid instruction.
- out_ready  input  1  decode accepts the IF/ID contents this cycle.
- out_instruction  output  INST_W  fetched instruction.
- out_pc  output  I_ADDR_W  address of out_instruction.
- halted  output  1  high while in HALTED state.

Behaviour:
- Reset (rst_n=0 at clk edge): pc=RESET_PC, state=IDLE, out_valid=0, out_instruction=0, out_pc=0, halted=0.
- FSM states: IDLE, FETCH, HALTED.
  - IDLE -> FETCH unconditionally on the next edge; no load.
  - FETCH -> HALTED when halt_req=1 (no redirect involvement required).
  - HALTED -> FETCH only on redirect_valid=1.
- Load condition in FETCH: load_en = (!out_valid || out_ready) && !redirect_valid && !halt_req.
- On load_en:
  - out_instruction <= imem_instruction.
  - out_pc <= pc.
  - out_valid <= 1.
  - pc <= (pc + PC_STEP) mod 2^I_ADDR_W, wrapping to 0 at top of memory.
- Stall (out_valid=1, out_ready=0): pc, out_instruction and out_pc hold; out_valid stays 1.
- Handshake: a transfer occurs when out_valid && out_ready. If the fetch register drains with no new load, out_valid <= 0.
- Redirect (any state except IDLE) has priority over load and halt:
  - pc <= {redirect_target[I_ADDR_W-1:1], 1'b0}.
  - out_valid <= 0 (flush, regardless of out_ready).
  - state <= FETCH, unless halt_req is also 1, in which case state <= HALTED.
- Redirect latency:
  - Redirect at cycle N -> imem_addr = target in N+1.
  - out_valid=1 with the target instruction in N+2.
- Halt: no further loads. An already-valid out register stays valid until consumed. halted=1 from the cycle after entry.
- Throughput: one instruction per cycle while out_ready=1.
- Reset mid-operation: reset overrides all inputs, including a pending redirect.
- Combinational paths: imem_addr depends only on registered pc; out_* are registered; no combinational path from out_ready to outputs.

Optional Feature:
- Macro: INSTRUCTION_FETCH_PERF_EN.
- Defined: adds output ports perf_fetch_count[15:0] and perf_stall_count[15:0].
  - perf_fetch_count increments on every load_en.
  - perf_stall_count increments on every cycle with out_valid && !out_ready.
  - Both counters saturate at 16'hFFFF, clear on reset, and are not affected by redirect.
- Not defined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset with RESET_PC=0 and out_ready=1, memory returning 16'h1000+addr -> out_valid first high 2 cycles after rst_n rises with out_pc=0, out_instruction=16'h1000; then out_pc=2, 4, 6 on consecutive cycles.
- Hold out_ready=0 for 3 cycles while out_pc=4 -> out_pc=4 and imem_addr=6 held for all 3 cycles; after release, out_pc=6 follows immediately.
- redirect_valid=1 with redirect_target=12'h0A5 while out_valid=1 -> next cycle out_valid=0 and imem_addr=12'h0A4; the cycle after, out_pc=12'h0A4.
- Start at pc=12'hFFE -> out_pc=12'hFFE, then out_pc=12'h000 (wrap).
- halt_req pulse with out_ready=0 -> halted=1, out_valid stays 1 with unchanged out_pc until out_ready=1, then out_valid=0; a later redirect to 12'h020 resumes with out_pc=12'h020.
- Assert rst_n=0 in the same cycle as redirect_valid=1 -> pc=RESET_PC and out_valid=0; with INSTRUCTION_FETCH_PERF_EN, both counters read 0.
